// File: rtl/rx_unpacker.sv
// rx_unpacker: splits 32-bit show-ahead FIFO words into 16-bit FX2 reads, low half first,
// with a one-word prefetch and a per-burst read cap.
module rx_unpacker #(
  parameter int PKT_WORDS16 = 256,
  parameter int LEVEL_W = 12
) (
  input  logic               usbclk,
  input  logic               reset,
  input  logic               RD_fx2,
  output logic [15:0]        usbdata_out,
  output logic               have_pkt_rdy,
  output logic               underrun,
  input  logic [31:0]        fifo_data,
  input  logic               fifo_empty,
  output logic               fifo_rdreq,
  input  logic [LEVEL_W-1:0] fifo_level
);
  typedef enum logic [1:0] {EMPTY, LOW, HIGH} state_t;
  state_t state, state_n;
  logic [31:0] hold, hold_n, nxt, nxt_n;
  logic nxt_valid, nxt_valid_n, rd_ok, pf, und_n;
  logic [15:0] dout_n;
  logic [8:0] burst_cnt;
  logic [LEVEL_W:0] level_sum;
  assign rd_ok = RD_fx2 && (burst_cnt < 9'(PKT_WORDS16));
  assign pf = !fifo_empty && !nxt_valid;
  assign level_sum = {1'b0, fifo_level} + (LEVEL_W+1)'(state != EMPTY) + (LEVEL_W+1)'(nxt_valid);
  always_comb begin
    state_n = state;
    hold_n = hold;
    nxt_n = nxt;
    nxt_valid_n = nxt_valid;
    dout_n = usbdata_out;
    fifo_rdreq = 1'b0;
    und_n = 1'b0;
    case (state)
      EMPTY: begin
        und_n = rd_ok;
        if (rd_ok) dout_n = '0;
        if (!fifo_empty) begin
          fifo_rdreq = 1'b1;
          hold_n = fifo_data;
          dout_n = fifo_data[15:0];
          state_n = LOW;
        end
      end
      LOW: begin
        if (pf) begin
          fifo_rdreq = 1'b1;
          nxt_n = fifo_data;
          nxt_valid_n = 1'b1;
        end
        if (rd_ok) begin
          dout_n = hold[31:16];
          state_n = HIGH;
        end
      end
      HIGH: begin
        if (rd_ok) begin
          if (nxt_valid) begin
            hold_n = nxt;
            dout_n = nxt[15:0];
            nxt_valid_n = 1'b0;
            state_n = LOW;
          end else if (!fifo_empty) begin
            fifo_rdreq = 1'b1;
            hold_n = fifo_data;
            dout_n = fifo_data[15:0];
            state_n = LOW;
          end else begin
            dout_n = '0;
            state_n = EMPTY;
          end
        end else if (pf) begin
          fifo_rdreq = 1'b1;
          nxt_n = fifo_data;
          nxt_valid_n = 1'b1;
        end
      end
      default: state_n = EMPTY;
    endcase
    if (reset) fifo_rdreq = 1'b0;
  end
  always_ff @(posedge usbclk) begin
    if (reset) begin
      state <= EMPTY;
      nxt_valid <= 1'b0;
      burst_cnt <= '0;
      usbdata_out <= '0;
      have_pkt_rdy <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state <= state_n;
      hold <= hold_n;
      nxt <= nxt_n;
      nxt_valid <= nxt_valid_n;
      usbdata_out <= dout_n;
      underrun <= und_n;
      have_pkt_rdy <= level_sum >= (LEVEL_W+1)'(PKT_WORDS16 / 2);
      burst_cnt <= !RD_fx2 ? '0 : burst_cnt + 9'(rd_ok);
    end
  end
endmodule
